// File: rtl/mproc_loader.sv
// mproc_loader: streams instruction words into the mproc program RAM,
// reads them back to verify an additive checksum, and holds mproc in
// reset until a verified load has completed.
module mproc_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t            state;
  logic [7:0]        len_r;
  logic [7:0]        wcnt;
  logic [7:0]        rcnt;
  logic [DATA_W-1:0] rsum;
  logic [DATA_W-1:0] rsum_final;
  logic              len_ok;

  // A legal load covers at least one word and never more than the RAM holds.
  assign len_ok = (len != 8'd0) && ({1'b0, len} <= DEPTH_L);

  // The last readback word arrives on the final VERIFY cycle and is folded in here.
  assign rsum_final = rsum + mem_dout;

  // The handshake and busy flag decode the state directly so that a word is accepted every WRITE cycle.
  assign in_ready = (state == WRITE);
  assign busy     = (state == WRITE) || (state == VERIFY);

  // Load sequencer: WRITE takes one word per cycle; VERIFY spends one cycle letting the
  // final write land, then issues len reads and compares once the last read data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_r     <= 8'd0;
      wcnt      <= 8'd0;
      rcnt      <= 8'd0;
      rsum      <= '0;
      checksum  <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          mem_wr <= 1'b0;
          if (start) begin
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            if (len_ok) begin
              len_r    <= len;
              wcnt     <= 8'd0;
              rcnt     <= 8'd0;
              rsum     <= '0;
              checksum <= '0;
              error    <= 1'b0;
              state    <= WRITE;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
        end

        WRITE: begin
          if (in_valid) begin
            mem_wr   <= 1'b1;
            mem_addr <= wcnt[ADDR_W-1:0];
            mem_din  <= in_data;
            checksum <= checksum + in_data;
            wcnt     <= wcnt + 8'd1;
            if (wcnt == len_r - 8'd1) begin
              state <= VERIFY;
            end
          end else begin
            mem_wr <= 1'b0;
          end
        end

        VERIFY: begin
          mem_wr <= 1'b0;
          rcnt   <= rcnt + 8'd1;
          if (rcnt == 8'd0) begin
            mem_addr <= '0;
          end else if (rcnt < len_r) begin
            mem_addr <= rcnt[ADDR_W-1:0];
          end
          if (rcnt >= 8'd2) begin
            rsum <= rsum_final;
          end
          if (rcnt == len_r + 8'd1) begin
            if (rsum_final == checksum) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              state     <= DONE;
            end else begin
              error     <= 1'b1;
              cpu_reset <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
